// File: rtl/alu_rs.sv
// alu_rs: integer-ALU reservation station; CDB wakeup, oldest-ready select via age matrix.
// Latency: dispatch->issue 2 cycles; CDB wakeup->issue 2 cycles (1 with RS_WAKEUP_BYPASS_EN).
// Backpressure: full blocks dispatch; the ALU always accepts, so issue never stalls.
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int DW      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    input  logic [DW-1:0]    in_Vj,
    input  logic [DW-1:0]    in_Vk,
    input  logic [TAG_W-1:0] in_Qj,
    input  logic [TAG_W-1:0] in_Qk,
    input  logic             in_Qj_busy,
    input  logic             in_Qk_busy,
    input  logic [DW-1:0]    in_imm,
    input  logic [DW-1:0]    in_pc,
    input  logic [TAG_W-1:0] in_rob_tag,
    output logic             full,
    input  logic             cdb0_valid,
    input  logic [TAG_W-1:0] cdb0_tag,
    input  logic [DW-1:0]    cdb0_value,
    input  logic             cdb1_valid,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [DW-1:0]    cdb1_value,
    output logic             alu_ena,
    output logic [OP_W-1:0]  alu_op,
    output logic [DW-1:0]    alu_A,
    output logic [DW-1:0]    alu_B,
    output logic [DW-1:0]    alu_imm,
    output logic [DW-1:0]    alu_pc,
    output logic [TAG_W-1:0] alu_rob_tag
);
    localparam int IW = $clog2(RS_SIZE);

    // entry storage
    logic [RS_SIZE-1:0] busy, qj_busy, qk_busy;
    logic [OP_W-1:0]    op      [RS_SIZE];
    logic [DW-1:0]      vj      [RS_SIZE];
    logic [DW-1:0]      vk      [RS_SIZE];
    logic [DW-1:0]      imm     [RS_SIZE];
    logic [DW-1:0]      pc      [RS_SIZE];
    logic [TAG_W-1:0]   qj      [RS_SIZE];
    logic [TAG_W-1:0]   qk      [RS_SIZE];
    logic [TAG_W-1:0]   rob_tag [RS_SIZE];
    // older[i][j]: entry i was dispatched before entry j
    logic [RS_SIZE-1:0] older   [RS_SIZE];

    logic [RS_SIZE-1:0] j_hit0, j_hit1, k_hit0, k_hit1, rdy_j, rdy_k, ready;
    logic [DW-1:0]      opa [RS_SIZE];
    logic [DW-1:0]      opb [RS_SIZE];
    logic [IW-1:0]      free_idx, sel_idx;
    logic               free_vld, sel_vld, accept;
    logic               dj_hit0, dj_hit1, dk_hit0, dk_hit1;

    // per-entry CDB tag matches, operand readiness and effective operand values
    always_comb begin
        j_hit0 = '0;
        j_hit1 = '0;
        k_hit0 = '0;
        k_hit1 = '0;
        rdy_j  = '0;
        rdy_k  = '0;
        ready  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            j_hit0[i] = busy[i] && qj_busy[i] && cdb0_valid && (cdb0_tag == qj[i]);
            j_hit1[i] = busy[i] && qj_busy[i] && cdb1_valid && (cdb1_tag == qj[i]);
            k_hit0[i] = busy[i] && qk_busy[i] && cdb0_valid && (cdb0_tag == qk[i]);
            k_hit1[i] = busy[i] && qk_busy[i] && cdb1_valid && (cdb1_tag == qk[i]);
`ifdef RS_WAKEUP_BYPASS_EN
            rdy_j[i] = !qj_busy[i] || j_hit0[i] || j_hit1[i];
            rdy_k[i] = !qk_busy[i] || k_hit0[i] || k_hit1[i];
            opa[i]   = !qj_busy[i] ? vj[i] : (j_hit0[i] ? cdb0_value : cdb1_value);
            opb[i]   = !qk_busy[i] ? vk[i] : (k_hit0[i] ? cdb0_value : cdb1_value);
`else
            rdy_j[i] = !qj_busy[i];
            rdy_k[i] = !qk_busy[i];
            opa[i]   = vj[i];
            opb[i]   = vk[i];
`endif
            ready[i] = busy[i] && rdy_j[i] && rdy_k[i];
        end
    end

    // oldest-ready select, lowest free slot, and dispatch acceptance
    always_comb begin
        logic blocked;
        sel_vld  = 1'b0;
        sel_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && ready[j] && older[j][i]) blocked = 1'b1;
            end
            if (ready[i] && !blocked && !sel_vld) begin
                sel_vld = 1'b1;
                sel_idx = IW'(i);
            end
            if (!busy[i] && !free_vld) begin
                free_vld = 1'b1;
                free_idx = IW'(i);
            end
        end
        full    = &busy;
        accept  = in_valid && !full && !clear;
        dj_hit0 = in_Qj_busy && cdb0_valid && (cdb0_tag == in_Qj);
        dj_hit1 = in_Qj_busy && cdb1_valid && (cdb1_tag == in_Qj);
        dk_hit0 = in_Qk_busy && cdb0_valid && (cdb0_tag == in_Qk);
        dk_hit1 = in_Qk_busy && cdb1_valid && (cdb1_tag == in_Qk);
    end

    // entry state: wakeup, free on issue, dispatch into lowest free slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op[i]      <= '0;
                vj[i]      <= '0;
                vk[i]      <= '0;
                imm[i]     <= '0;
                pc[i]      <= '0;
                qj[i]      <= '0;
                qk[i]      <= '0;
                rob_tag[i] <= '0;
                older[i]   <= '0;
            end
        end else if (clear) begin
            busy <= '0;
            for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (j_hit0[i]) begin
                    vj[i]      <= cdb0_value;
                    qj_busy[i] <= 1'b0;
                end else if (j_hit1[i]) begin
                    vj[i]      <= cdb1_value;
                    qj_busy[i] <= 1'b0;
                end
                if (k_hit0[i]) begin
                    vk[i]      <= cdb0_value;
                    qk_busy[i] <= 1'b0;
                end else if (k_hit1[i]) begin
                    vk[i]      <= cdb1_value;
                    qk_busy[i] <= 1'b0;
                end
            end
            if (sel_vld) busy[sel_idx] <= 1'b0;
            // free slot is never the selected one, so both writes coexist
            if (accept && free_vld) begin
                busy[free_idx]    <= 1'b1;
                op[free_idx]      <= in_op;
                imm[free_idx]     <= in_imm;
                pc[free_idx]      <= in_pc;
                rob_tag[free_idx] <= in_rob_tag;
                qj[free_idx]      <= in_Qj;
                qk[free_idx]      <= in_Qk;
                vj[free_idx]      <= dj_hit0 ? cdb0_value : (dj_hit1 ? cdb1_value : in_Vj);
                vk[free_idx]      <= dk_hit0 ? cdb0_value : (dk_hit1 ? cdb1_value : in_Vk);
                qj_busy[free_idx] <= in_Qj_busy && !dj_hit0 && !dj_hit1;
                qk_busy[free_idx] <= in_Qk_busy && !dk_hit0 && !dk_hit1;
                older[free_idx]   <= '0;
                // stale bits from freed entries are harmless: non-busy rows never block
                for (int i = 0; i < RS_SIZE; i++) older[i][free_idx] <= busy[i];
            end
        end
    end

    // registered issue port; data holds when nothing issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ena     <= 1'b0;
            alu_op      <= '0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_tag <= '0;
        end else if (clear) begin
            alu_ena <= 1'b0;
        end else begin
            alu_ena <= sel_vld;
            if (sel_vld) begin
                alu_op      <= op[sel_idx];
                alu_A       <= opa[sel_idx];
                alu_B       <= opb[sel_idx];
                alu_imm     <= imm[sel_idx];
                alu_pc      <= pc[sel_idx];
                alu_rob_tag <= rob_tag[sel_idx];
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed scenarios plus random traffic against an ordered-list model.
// Expected issues are queued with their due cycle; a monitor pops and compares on alu_ena.
// Build with or without RS_WAKEUP_BYPASS_EN; the model follows the same define.
module tb_alu_rs;
    localparam int RS_SIZE = 8;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_Qj_busy, in_Qk_busy;
    logic [5:0]  in_op;
    logic [31:0] in_Vj, in_Vk, in_imm, in_pc;
    logic [3:0]  in_Qj, in_Qk, in_rob_tag;
    logic        full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_value, cdb1_value;
    logic        alu_ena;
    logic [5:0]  alu_op;
    logic [31:0] alu_A, alu_B, alu_imm, alu_pc;
    logic [3:0]  alu_rob_tag;

    alu_rs #(.RS_SIZE(RS_SIZE), .TAG_W(4), .OP_W(6), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_op(in_op),
        .in_Vj(in_Vj), .in_Vk(in_Vk), .in_Qj(in_Qj), .in_Qk(in_Qk),
        .in_Qj_busy(in_Qj_busy), .in_Qk_busy(in_Qk_busy), .in_imm(in_imm), .in_pc(in_pc),
        .in_rob_tag(in_rob_tag), .full(full),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
        .alu_ena(alu_ena), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_tag(alu_rob_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  qj, qk, rob;
        logic        qjb, qkb;
    } ent_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, imm, pc;
        logic [3:0]  rob;
        int          cyc;
    } exp_t;

    ent_t mq[$];   // model contents, oldest first
    exp_t sb[$];   // expected issues, in order
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // resolve pending operands against this cycle's broadcasts, cdb0 first
    function automatic ent_t wake(input ent_t e_in);
        ent_t e = e_in;
        if (e.qjb) begin
            if (cdb0_valid && cdb0_tag == e.qj) begin e.vj = cdb0_value; e.qjb = 1'b0; end
            else if (cdb1_valid && cdb1_tag == e.qj) begin e.vj = cdb1_value; e.qjb = 1'b0; end
        end
        if (e.qkb) begin
            if (cdb0_valid && cdb0_tag == e.qk) begin e.vk = cdb0_value; e.qkb = 1'b0; end
            else if (cdb1_valid && cdb1_tag == e.qk) begin e.vk = cdb1_value; e.qkb = 1'b0; end
        end
        return e;
    endfunction

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        int   cnt;
        int   pick;
        ent_t w;
        exp_t x;
        if (!rst_n || clear) begin
            mq.delete();
            return;
        end
        cnt  = mq.size();
        pick = -1;
        for (int i = 0; i < mq.size(); i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            w = wake(mq[i]);
`else
            w = mq[i];
`endif
            if (pick < 0 && !w.qjb && !w.qkb) begin
                pick  = i;
                x.op  = w.op;  x.a  = w.vj; x.b = w.vk;
                x.imm = w.imm; x.pc = w.pc; x.rob = w.rob;
                x.cyc = cyc + 1;
            end
        end
        if (pick >= 0) begin
            sb.push_back(x);
            mq.delete(pick);
        end
        foreach (mq[i]) mq[i] = wake(mq[i]);
        if (in_valid && cnt < RS_SIZE) begin
            w.op = in_op; w.vj = in_Vj; w.vk = in_Vk; w.imm = in_imm; w.pc = in_pc;
            w.qj = in_Qj; w.qk = in_Qk; w.qjb = in_Qj_busy; w.qkb = in_Qk_busy;
            w.rob = in_rob_tag;
            mq.push_back(wake(w));
        end
    endtask

    // called at a falling edge with inputs set; checks full, models the next edge, waits
    task automatic tick();
        chk("full", 32'(full), 32'(mq.size() == RS_SIZE));
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; clear = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [3:0] qj, input logic qjb,
                            input logic [3:0] qk, input logic qkb, input logic [3:0] rob);
        in_valid = 1'b1; in_op = op; in_Vj = vj; in_Vk = vk;
        in_Qj = qj; in_Qj_busy = qjb; in_Qk = qk; in_Qk_busy = qkb; in_rob_tag = rob;
        in_imm = $urandom; in_pc = $urandom;
    endtask

    task automatic set_cdb0(input logic [3:0] t, input logic [31:0] v);
        cdb0_valid = 1'b1; cdb0_tag = t; cdb0_value = v;
    endtask

    task automatic set_cdb1(input logic [3:0] t, input logic [31:0] v);
        cdb1_valid = 1'b1; cdb1_tag = t; cdb1_value = v;
    endtask

    // monitor: every issue must match the head of the expected queue, on its due cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (alu_ena) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL spurious_issue: alu_ena=1 rob=%0d cycle %0d, expected no issue",
                                 alu_rob_tag, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("issue_cycle", 32'(cyc), 32'(e.cyc));
                        chk("alu_op", 32'(alu_op), 32'(e.op));
                        chk("alu_A", alu_A, e.a);
                        chk("alu_B", alu_B, e.b);
                        chk("alu_imm", alu_imm, e.imm);
                        chk("alu_pc", alu_pc, e.pc);
                        chk("alu_rob_tag", 32'(alu_rob_tag), 32'(e.rob));
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    n_chk++;
                    $display("FAIL missing_issue: alu_ena=0 cycle %0d, expected rob=%0d", cyc, sb[0].rob);
                    sb.delete(0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        in_op = '0; in_Vj = '0; in_Vk = '0; in_Qj = '0; in_Qk = '0;
        in_Qj_busy = 1'b0; in_Qk_busy = 1'b0; in_imm = '0; in_pc = '0; in_rob_tag = '0;
        cdb0_tag = '0; cdb1_tag = '0; cdb0_value = '0; cdb1_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_alu_ena", 32'(alu_ena), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_alu_A", alu_A, 32'd0);
        chk("rst_alu_rob_tag", 32'(alu_rob_tag), 32'd0);
        rst_n = 1'b1;

        // ready ADD: Vj=5, Vk=7, rob 3
        set_disp(6'h01, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
        tick(); idle(); repeat (4) tick();

        // wakeup via cdb1 on tag 9; unrelated broadcast on tag 8 first
        set_disp(6'h02, 32'd0, 32'd1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd4);
        tick(); idle(); tick();
        set_cdb0(4'd8, 32'h55); tick(); idle(); repeat (2) tick();
        set_cdb1(4'd9, 32'h100); tick(); idle(); repeat (4) tick();

        // oldest first: A pending on 2, B and C ready, late wakeup
        set_disp(6'h0a, 32'd0, 32'd11, 4'd2, 1'b1, 4'd0, 1'b0, 4'd5); tick();
        set_disp(6'h0b, 32'd12, 32'd13, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6); tick();
        set_disp(6'h0c, 32'd14, 32'd15, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7); tick();
        idle(); repeat (3) tick();
        set_cdb0(4'd2, 32'hA0); tick(); idle(); repeat (3) tick();
        // A and C ready together: A must win
        set_disp(6'h0a, 32'd0, 32'd21, 4'd2, 1'b1, 4'd0, 1'b0, 4'd5); tick();
        set_disp(6'h0b, 32'd22, 32'd23, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6); tick();
        set_disp(6'h0c, 32'd24, 32'd25, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7);
        set_cdb0(4'd2, 32'hA1); tick(); idle(); repeat (5) tick();

        // full: eight entries pending on tag 1, ninth rejected
        for (int i = 0; i < 8; i++) begin
            set_disp(6'(i + 16), 32'(i), 32'(i + 100), 4'd1, 1'b1, 4'd1, 1'b1, 4'(i + 8));
            tick();
        end
        set_disp(6'h3f, 32'd1, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15); tick();
        idle(); tick();
        set_cdb1(4'd1, 32'hBEEF); tick(); idle(); repeat (12) tick();

        // flush with five entries, together with dispatch and broadcast
        for (int i = 0; i < 5; i++) begin
            set_disp(6'(i + 32), 32'd0, 32'd0, 4'd5, 1'b1, 4'd0, 1'b0, 4'(i));
            tick();
        end
        set_disp(6'h30, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12);
        set_cdb0(4'd5, 32'h77); clear = 1'b1; tick();
        idle(); repeat (6) tick();

        // async reset while an issue is on the outputs
        set_disp(6'h05, 32'd50, 32'd51, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1); tick();
        set_disp(6'h06, 32'd52, 32'd53, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2); tick();
        idle();
        chk("pre_reset_alu_ena", 32'(alu_ena), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_alu_ena", 32'(alu_ena), 32'd0);
        chk("async_rst_alu_op", 32'(alu_op), 32'd0);
        chk("async_rst_alu_A", alu_A, 32'd0);
        chk("async_rst_alu_B", alu_B, 32'd0);
        chk("async_rst_alu_pc", alu_pc, 32'd0);
        chk("async_rst_alu_rob_tag", 32'(alu_rob_tag), 32'd0);
        chk("async_rst_full", 32'(full), 32'd0);
        mq.delete();
        sb.delete();
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_op      = 6'($urandom);
            in_Vj      = $urandom;
            in_Vk      = $urandom;
            in_imm     = $urandom;
            in_pc      = $urandom;
            in_Qj      = 4'($urandom_range(0, 7));
            in_Qk      = 4'($urandom_range(0, 7));
            in_Qj_busy = ($urandom_range(0, 1) == 1);
            in_Qk_busy = ($urandom_range(0, 1) == 1);
            in_rob_tag = 4'($urandom);
            cdb0_valid = ($urandom_range(0, 9) < 3);
            cdb0_tag   = 4'($urandom_range(0, 7));
            cdb0_value = $urandom;
            cdb1_valid = ($urandom_range(0, 9) < 3);
            cdb1_tag   = 4'($urandom_range(0, 7));
            cdb1_value = $urandom;
            clear      = ($urandom_range(0, 99) == 0);
            tick();
        end

        // drain: broadcast every tag, then everything left must issue
        idle();
        for (int t = 0; t < 16; t++) begin
            set_cdb0(4'(t), $urandom);
            tick();
        end
        idle(); repeat (12) tick();
        chk("drain_expected_empty", 32'(sb.size()), 32'd0);
        chk("drain_model_empty", 32'(mq.size()), 32'd0);
        chk("drain_full", 32'(full), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
